// File: rtl/sync_join2_32b.sv
// Two-branch 32-bit join stage. Each branch token is buffered in its own
// small FIFO; heads are paired in arrival order and emitted as one joined
// token under credit-based downstream flow control. The two copies are
// compared and a saturating mismatch count is kept for fork-integrity checks.
module sync_join2_32b #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CREDITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_drive0,
  input  logic        i_drive1,
  input  logic [31:0] i_data0,
  input  logic [31:0] i_data1,
  output logic        o_free0,
  output logic        o_free1,
  output logic        o_driveNext,
  output logic [31:0] o_data0,
  output logic [31:0] o_data1,
  output logic        o_match,
  input  logic        i_freeNext,
  output logic        o_overflow,
  output logic        o_credit_err,
  output logic [15:0] o_mismatch_cnt
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt  = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneCnt   = (AW+1)'(1);
  localparam logic [AW-1:0] OnePtr = AW'(1);
  localparam logic [3:0]  CredMax  = 4'(CREDITS);

  logic [31:0]   mem0_q [DEPTH];
  logic [31:0]   mem1_q [DEPTH];
  logic [AW-1:0] wp0_q, wp0_d, rp0_q, rp0_d;
  logic [AW-1:0] wp1_q, wp1_d, rp1_q, rp1_d;
  logic [AW:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [3:0]    cred_q, cred_d;
  logic          ovf_q, ovf_d;
  logic          cerr_q, cerr_d;
  logic [15:0]   mis_q, mis_d;
  logic          join_ev_q;
  logic [31:0]   data0_q, data0_d, data1_q, data1_d;
  logic          match_q, match_d;

  logic          join_ev, push0, push1;
  logic [31:0]   head0, head1;

  // Join decision, push acceptance and all next-state values.
  always_comb begin
    head0   = mem0_q[rp0_q];
    head1   = mem1_q[rp1_q];
    join_ev = (cnt0_q != '0) && (cnt1_q != '0) && (cred_q != 4'd0);
    // A pop in the same cycle frees a slot, so a push at full is accepted.
    push0   = i_drive0 && ((cnt0_q != FullCnt) || join_ev);
    push1   = i_drive1 && ((cnt1_q != FullCnt) || join_ev);

    wp0_d = push0 ? wp0_q + OnePtr : wp0_q;
    wp1_d = push1 ? wp1_q + OnePtr : wp1_q;
    rp0_d = join_ev ? rp0_q + OnePtr : rp0_q;
    rp1_d = join_ev ? rp1_q + OnePtr : rp1_q;

    cnt0_d = cnt0_q;
    case ({push0, join_ev})
      2'b10:   cnt0_d = cnt0_q + OneCnt;
      2'b01:   cnt0_d = cnt0_q - OneCnt;
      default: cnt0_d = cnt0_q;
    endcase
    cnt1_d = cnt1_q;
    case ({push1, join_ev})
      2'b10:   cnt1_d = cnt1_q + OneCnt;
      2'b01:   cnt1_d = cnt1_q - OneCnt;
      default: cnt1_d = cnt1_q;
    endcase

    ovf_d  = ovf_q | (i_drive0 & ~push0) | (i_drive1 & ~push1);
    cred_d = cred_q;
    cerr_d = cerr_q;
    case ({join_ev, i_freeNext})
      2'b10: cred_d = cred_q - 4'd1;
      2'b01: begin
        if (cred_q == CredMax) cerr_d = 1'b1;
        else                   cred_d = cred_q + 4'd1;
      end
      default: cred_d = cred_q;
    endcase

    data0_d = data0_q;
    data1_d = data1_q;
    match_d = match_q;
    mis_d   = mis_q;
    if (join_ev) begin
      data0_d = head0;
      data1_d = head1;
      match_d = (head0 == head1);
      if ((head0 != head1) && (mis_q != 16'hFFFF)) mis_d = mis_q + 16'd1;
    end
  end

  // Control state, flags and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp0_q     <= '0;
      wp1_q     <= '0;
      rp0_q     <= '0;
      rp1_q     <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      cred_q    <= CredMax;
      ovf_q     <= 1'b0;
      cerr_q    <= 1'b0;
      mis_q     <= '0;
      join_ev_q <= 1'b0;
      data0_q   <= '0;
      data1_q   <= '0;
      match_q   <= 1'b0;
    end else begin
      wp0_q     <= wp0_d;
      wp1_q     <= wp1_d;
      rp0_q     <= rp0_d;
      rp1_q     <= rp1_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      cred_q    <= cred_d;
      ovf_q     <= ovf_d;
      cerr_q    <= cerr_d;
      mis_q     <= mis_d;
      join_ev_q <= join_ev;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      match_q   <= match_d;
    end
  end

  // Branch buffer storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem0_q[i] <= '0;
        mem1_q[i] <= '0;
      end
    end else begin
      if (push0) mem0_q[wp0_q] <= i_data0;
      if (push1) mem1_q[wp1_q] <= i_data1;
    end
  end

  assign o_driveNext    = join_ev_q;
  assign o_free0        = join_ev_q;
  assign o_free1        = join_ev_q;
  assign o_data0        = data0_q;
  assign o_data1        = data1_q;
  assign o_match        = match_q;
  assign o_overflow     = ovf_q;
  assign o_credit_err   = cerr_q;
  assign o_mismatch_cnt = mis_q;

endmodule

// File: tb/tb_sync_join2_32b.sv
// Directed bench for sync_join2_32b (DEPTH=2, CREDITS=2).
module tb_sync_join2_32b;

  logic        clk;
  logic        rst;
  logic        i_drive0, i_drive1, i_freeNext;
  logic [31:0] i_data0, i_data1;
  logic        o_free0, o_free1, o_driveNext, o_match, o_overflow, o_credit_err;
  logic [31:0] o_data0, o_data1;
  logic [15:0] o_mismatch_cnt;

  int n_tests;
  int n_fail;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  sync_join2_32b #(.DEPTH(2), .CREDITS(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_drive0       (i_drive0),
    .i_drive1       (i_drive1),
    .i_data0        (i_data0),
    .i_data1        (i_data1),
    .o_free0        (o_free0),
    .o_free1        (o_free1),
    .o_driveNext    (o_driveNext),
    .o_data0        (o_data0),
    .o_data1        (o_data1),
    .o_match        (o_match),
    .i_freeNext     (i_freeNext),
    .o_overflow     (o_overflow),
    .o_credit_err   (o_credit_err),
    .o_mismatch_cnt (o_mismatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample at the falling edge and log any joined token.
  task automatic tick();
    @(negedge clk);
    if (o_driveNext) begin
      q0.push_back(o_data0);
      q1.push_back(o_data1);
    end
  endtask

  task automatic idle();
    i_drive0 = 1'b0;
    i_drive1 = 1'b0;
    i_freeNext = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    q0.delete();
    q1.delete();
  endtask

  task automatic ret_credit(input int n);
    for (int i = 0; i < n; i++) begin
      i_freeNext = 1'b1;
      tick();
    end
    i_freeNext = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    i_data0 = '0;
    i_data1 = '0;
    idle();
    rst = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_drv", {31'd0, o_driveNext}, 32'd0);
    check("rst_free", {30'd0, o_free0, o_free1}, 32'd0);
    check("rst_data0", o_data0, 32'd0);
    check("rst_flags", {29'd0, o_match, o_overflow, o_credit_err}, 32'd0);
    check("rst_cnt", {16'd0, o_mismatch_cnt}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single matched pair: driveNext two cycles after the drives
    i_drive0 = 1'b1; i_data0 = 32'hA5A5_0001;
    i_drive1 = 1'b1; i_data1 = 32'hA5A5_0001;
    tick();
    idle();
    check("pair_lat1", {31'd0, o_driveNext}, 32'd0);
    tick();
    check("pair_drv", {31'd0, o_driveNext}, 32'd1);
    check("pair_free", {30'd0, o_free0, o_free1}, 32'd3);
    check("pair_d0", o_data0, 32'hA5A5_0001);
    check("pair_d1", o_data1, 32'hA5A5_0001);
    check("pair_match", {31'd0, o_match}, 32'd1);
    check("pair_cnt", {16'd0, o_mismatch_cnt}, 32'd0);
    tick();
    check("pair_pulse", {31'd0, o_driveNext}, 32'd0);
    check("pair_hold", o_data0, 32'hA5A5_0001);
    ret_credit(1);

    // Skewed arrival with differing words
    i_drive0 = 1'b1; i_data0 = 32'h11;
    tick();
    idle();
    repeat (3) tick();
    check("skew_wait", {31'd0, o_driveNext}, 32'd0);
    i_drive1 = 1'b1; i_data1 = 32'h22;
    tick();
    idle();
    check("skew_lat1", {31'd0, o_driveNext}, 32'd0);
    tick();
    check("skew_drv", {31'd0, o_driveNext}, 32'd1);
    check("skew_d0", o_data0, 32'h11);
    check("skew_d1", o_data1, 32'h22);
    check("skew_match", {31'd0, o_match}, 32'd0);
    check("skew_cnt", {16'd0, o_mismatch_cnt}, 32'd1);
    tick();
    ret_credit(1);
    q0.delete(); q1.delete();

    // Credit stall: three pairs, only two joins until a credit returns
    i_drive0 = 1'b1; i_drive1 = 1'b1;
    i_data0 = 32'h100; i_data1 = 32'h100; tick();
    i_data0 = 32'h200; i_data1 = 32'h201; tick();
    i_data0 = 32'h300; i_data1 = 32'h300; tick();
    idle();
    repeat (5) tick();
    check("stall_joins", q0.size(), 32'd2);
    if (q0.size() == 2) begin
      check("stall_j0", q0[0], 32'h100);
      check("stall_j1d0", q0[1], 32'h200);
      check("stall_j1d1", q1[1], 32'h201);
    end
    check("stall_cnt", {16'd0, o_mismatch_cnt}, 32'd2);
    i_freeNext = 1'b1;
    tick();
    i_freeNext = 1'b0;
    check("stall_lat1", {31'd0, o_driveNext}, 32'd0);
    tick();
    check("stall_drv", {31'd0, o_driveNext}, 32'd1);
    check("stall_d0", o_data0, 32'h300);
    check("stall_match", {31'd0, o_match}, 32'd1);
    tick();
    ret_credit(2);
    check("stall_cerr", {31'd0, o_credit_err}, 32'd0);
    q0.delete(); q1.delete();

    // Push into a full buffer in the pop cycle is accepted
    i_drive0 = 1'b1; i_data0 = 32'h50; tick();
    i_data0 = 32'h51; tick();
    i_drive0 = 1'b0;
    i_drive1 = 1'b1; i_data1 = 32'h60; tick();
    i_drive1 = 1'b0;
    i_drive0 = 1'b1; i_data0 = 32'h52; tick();
    idle();
    check("fpp_ovf", {31'd0, o_overflow}, 32'd0);
    i_drive1 = 1'b1; i_data1 = 32'h61; tick();
    idle();
    repeat (2) tick();
    ret_credit(2);
    i_drive1 = 1'b1; i_data1 = 32'h62; tick();
    idle();
    repeat (3) tick();
    ret_credit(1);
    check("fpp_joins", q0.size(), 32'd3);
    if (q0.size() == 3) begin
      check("fpp_j0", q0[0], 32'h50);
      check("fpp_j1", q0[1], 32'h51);
      check("fpp_j2", q0[2], 32'h52);
      check("fpp_j2b", q1[2], 32'h62);
    end
    check("fpp_ovf_end", {31'd0, o_overflow}, 32'd0);
    check("fpp_cerr", {31'd0, o_credit_err}, 32'd0);

    // Overflow: third branch-0 drive dropped
    do_reset();
    i_drive0 = 1'b1; i_data0 = 32'hA; tick();
    i_data0 = 32'hB; tick();
    check("ovf_before", {31'd0, o_overflow}, 32'd0);
    i_data0 = 32'hC; tick();
    idle();
    check("ovf_set", {31'd0, o_overflow}, 32'd1);
    i_drive1 = 1'b1; i_data1 = 32'hD1; tick();
    i_data1 = 32'hD2; tick();
    idle();
    repeat (4) tick();
    check("ovf_joins", q0.size(), 32'd2);
    if (q0.size() == 2) begin
      check("ovf_j0", q0[0], 32'hA);
      check("ovf_j1", q0[1], 32'hB);
    end
    check("ovf_cnt", {16'd0, o_mismatch_cnt}, 32'd2);
    check("ovf_sticky", {31'd0, o_overflow}, 32'd1);
    ret_credit(2);
    // Credit return at full credit is an error
    ret_credit(1);
    check("cerr_set", {31'd0, o_credit_err}, 32'd1);

    // Async reset mid-stream with one branch-0 entry buffered
    i_drive0 = 1'b1; i_data0 = 32'h77; tick();
    idle();
    #2 rst = 1'b0;
    #1;
    check("arst_flags", {29'd0, o_overflow, o_credit_err, o_match}, 32'd0);
    check("arst_cnt", {16'd0, o_mismatch_cnt}, 32'd0);
    check("arst_data", o_data0 | o_data1, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    q0.delete(); q1.delete();
    i_drive1 = 1'b1; i_data1 = 32'h88; tick();
    idle();
    repeat (3) tick();
    check("arst_empty", q0.size(), 32'd0);
    i_drive0 = 1'b1; i_data0 = 32'h89; tick();
    idle();
    repeat (3) tick();
    check("arst_join", q0.size(), 32'd1);
    if (q0.size() == 1) check("arst_jd0", q0[0], 32'h89);
    ret_credit(1);
    check("arst_cerr", {31'd0, o_credit_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
